// File: rtl/hit_filter_array.sv
// Multi-channel hit front end: synchronise, detect rising edges, apply per-channel dead time.
// Define HIT_FILTER_GLITCH_EN to require s high for two cycles before an edge is recognised.
module hit_filter_array #(
    parameter int unsigned N_CH        = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEAD_W      = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   hit,
    input  logic [N_CH-1:0]   ch_enable,
    input  logic [DEAD_W-1:0] dead_time,
    output logic [N_CH-1:0]   filtered_hit,
    output logic [N_CH-1:0]   hit_word,
    output logic              valid,
    output logic [CNT_W-1:0]  reject_cnt
);

    typedef enum logic {StIdle, StDead} state_e;

    // Six spare bits cover a popcount of up to 32 channels on top of a saturated count.
    localparam int unsigned    SumW   = CNT_W + 6;
    localparam logic [SumW-1:0] CntMax = {6'd0, {CNT_W{1'b1}}};

    logic [N_CH-1:0]   sync_q [SYNC_STAGES];
    logic [N_CH-1:0]   s;
    logic [N_CH-1:0]   s_d_q;
    logic [N_CH-1:0]   edge_det;
    state_e            state_q [N_CH];
    state_e            state_d [N_CH];
    logic [DEAD_W-1:0] cnt_q [N_CH];
    logic [DEAD_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]   accept;
    logic [N_CH-1:0]   reject;
    logic [SumW-1:0]   rej_sum;
    logic [CNT_W-1:0]  reject_cnt_d;

    assign s = sync_q[SYNC_STAGES-1];

`ifdef HIT_FILTER_GLITCH_EN
    logic [N_CH-1:0] s_dd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_dd_q <= '0;
        end else begin
            s_dd_q <= s_d_q;
        end
    end

    assign edge_det = s & s_d_q & ~s_dd_q;
`else
    assign edge_det = s & ~s_d_q;
`endif

    always_comb begin
        accept  = '0;
        reject  = '0;
        rej_sum = {{(SumW-CNT_W){1'b0}}, reject_cnt};
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!ch_enable[i]) begin
                state_d[i] = StIdle;
                cnt_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    StIdle: begin
                        if (edge_det[i]) begin
                            accept[i] = 1'b1;
                            if (dead_time != '0) begin
                                state_d[i] = StDead;
                                cnt_d[i]   = dead_time;
                            end
                        end
                    end
                    StDead: begin
                        // Edges seen while dead are dropped without reloading the counter.
                        reject[i] = edge_det[i];
                        cnt_d[i]  = cnt_q[i] - DEAD_W'(1);
                        if (cnt_q[i] == DEAD_W'(1)) begin
                            state_d[i] = StIdle;
                        end
                    end
                    default: state_d[i] = StIdle;
                endcase
            end
            rej_sum = rej_sum + {{(SumW-1){1'b0}}, reject[i]};
        end
        reject_cnt_d = (rej_sum > CntMax) ? {CNT_W{1'b1}} : rej_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= '0;
            end
            s_d_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
            filtered_hit <= '0;
            hit_word     <= '0;
            valid        <= 1'b0;
            reject_cnt   <= '0;
        end else begin
            sync_q[0] <= hit;
            for (int j = 1; j < SYNC_STAGES; j++) begin
                sync_q[j] <= sync_q[j-1];
            end
            s_d_q <= s;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            filtered_hit <= accept;
            hit_word     <= filtered_hit;
            valid        <= |filtered_hit;
            reject_cnt   <= reject_cnt_d;
        end
    end

endmodule

// File: tb/tb_hit_filter_array.sv
// Bench for hit_filter_array: directed scenarios plus random traffic against a
// timestamp-based reference model; a second instance with a 2-bit reject counter.
`timescale 1ns/1ps
module tb_hit_filter_array;

    localparam int unsigned N_CH = 8;
    localparam int unsigned SYNC = 2;
`ifdef HIT_FILTER_GLITCH_EN
    localparam bit          GLITCH = 1'b1;
    localparam int unsigned LAT    = SYNC + 2;
`else
    localparam bit          GLITCH = 1'b0;
    localparam int unsigned LAT    = SYNC + 1;
`endif

    logic            clk;
    logic            rst;
    logic [N_CH-1:0] hit;
    logic [N_CH-1:0] ch_enable;
    logic [7:0]      dead_time;
    logic [N_CH-1:0] filtered_hit, hit_word, filt2, word2;
    logic            valid, valid2;
    logic [15:0]     rcnt;
    logic [1:0]      rcnt2;

    hit_filter_array #(.N_CH(N_CH), .SYNC_STAGES(SYNC), .DEAD_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .hit(hit), .ch_enable(ch_enable), .dead_time(dead_time),
        .filtered_hit(filtered_hit), .hit_word(hit_word), .valid(valid), .reject_cnt(rcnt)
    );

    hit_filter_array #(.N_CH(N_CH), .SYNC_STAGES(SYNC), .DEAD_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .hit(hit), .ch_enable(ch_enable), .dead_time(dead_time),
        .filtered_hit(filt2), .hit_word(word2), .valid(valid2), .reject_cnt(rcnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: hs[n] is the hit vector sampled n+1 edges ago; a channel is dead
    // for every decision edge up to and including dead_until.
    logic [N_CH-1:0] hs [0:7];
    longint          dead_until [N_CH];
    longint          cyc_n = 0;
    logic [N_CH-1:0] exp_filt, exp_word;
    logic            exp_valid;
    int              rej_total;

    always @(posedge clk) begin : model
        logic [N_CH-1:0] nf, sv, sdv, sddv, ev;
        sv   = hs[SYNC-1];
        sdv  = hs[SYNC];
        sddv = hs[SYNC+1];
        ev   = GLITCH ? (sv & sdv & ~sddv) : (sv & ~sdv);
        if (rst) begin
            for (int j = 0; j < 8; j++) hs[j] = '0;
            for (int c = 0; c < N_CH; c++) dead_until[c] = -1;
            exp_filt  = '0;
            exp_word  = '0;
            exp_valid = 1'b0;
            rej_total = 0;
        end else begin
            exp_word  = exp_filt;
            exp_valid = |exp_filt;
            nf = '0;
            for (int c = 0; c < N_CH; c++) begin
                if (!ch_enable[c]) begin
                    dead_until[c] = -1;
                end else if (ev[c]) begin
                    if (cyc_n <= dead_until[c]) begin
                        rej_total++;
                    end else begin
                        nf[c] = 1'b1;
                        if (dead_time != 0) dead_until[c] = cyc_n + longint'(dead_time);
                    end
                end
            end
            exp_filt = nf;
            for (int j = 7; j > 0; j--) hs[j] = hs[j-1];
            hs[0] = hit;
        end
        cyc_n++;
    end

    int pulses [N_CH];

    task automatic cyc();
        @(negedge clk);
        check("filtered_hit", filtered_hit, exp_filt);
        check("hit_word", hit_word, exp_word);
        check("valid", valid, exp_valid);
        check("reject_cnt", rcnt, (rej_total > 65535) ? 65535 : rej_total);
        check("reject_cnt_sat", rcnt2, (rej_total > 3) ? 3 : rej_total);
        for (int c = 0; c < N_CH; c++) if (filtered_hit[c]) pulses[c]++;
    endtask

    task automatic drive_ch(input int ch, input logic [31:0] pat, input int len);
        for (int k = 0; k < len; k++) begin
            hit[ch] = pat[k];
            cyc();
        end
        hit[ch] = 1'b0;
    endtask

    int r0;

    initial begin
        rst       = 1'b1;
        hit       = '0;
        ch_enable = '1;
        dead_time = 8'd4;
        for (int c = 0; c < N_CH; c++) pulses[c] = 0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        check("rst_filt", filtered_hit, 0);
        check("rst_word", hit_word, 0);
        check("rst_valid", valid, 0);
        check("rst_rcnt", rcnt, 0);

        // Single edge on ch3 and its latency.
        hit[3] = 1'b1;
        for (int j = 1; j <= LAT + 1; j++) begin
            cyc();
            if (j == LAT) check("lat_pulse", filtered_hit, 8'h08);
            else          check("lat_quiet", filtered_hit, 8'h00);
            if (j == LAT + 1) begin
                check("lat_word", hit_word, 8'h08);
                check("lat_valid", valid, 1);
            end
        end
        cyc();
        hit[3] = 1'b0;
        repeat (8) cyc();

        // Dead time 4: rises giving decisions at accept+2 (reject) and accept+5 (accept).
        pulses[0] = 0;
        drive_ch(0, 32'h65, 7);
        repeat (10) cyc();
        check("dt_reject", rcnt, 1);
        check("dt_pulses", pulses[0], 2);

        // Dead time 0: ten edges every two cycles are all accepted.
        dead_time = 8'd0;
        pulses[1] = 0;
        r0 = int'(rcnt);
        drive_ch(1, 32'h55555, 20);
        repeat (6) cyc();
        check("dt0_pulses", pulses[1], 10);
        check("dt0_rcnt", rcnt, r0);

        // Long dead time: six rejects saturate the 2-bit counter.
        dead_time = 8'd20;
        drive_ch(0, 32'h1555, 14);
        repeat (4) cyc();
        check("sat_rcnt2", rcnt2, 3);
        check("sat_rcnt", rcnt, 7);
        repeat (25) cyc();
        r0 = int'(rcnt);
        hit[0] = 1'b1; hit[5] = 1'b1; cyc();
        hit[0] = 1'b0; hit[5] = 1'b0; cyc();
        hit[0] = 1'b1; hit[5] = 1'b1; cyc();
        hit[0] = 1'b0; hit[5] = 1'b0;
        repeat (5) cyc();
        check("same_cycle_rej", int'(rcnt) - r0, 2);
        repeat (25) cyc();

        // Disabled channel, enabling while high, reset during dead time.
        ch_enable[2] = 1'b0;
        pulses[2] = 0;
        r0 = int'(rcnt);
        drive_ch(2, 32'h55, 8);
        repeat (5) cyc();
        check("dis_pulses", pulses[2], 0);
        check("dis_rcnt", rcnt, r0);
        hit[2] = 1'b1;
        repeat (4) cyc();
        ch_enable[2] = 1'b1;
        repeat (6) cyc();
        check("en_high_pulses", pulses[2], 0);
        hit[2] = 1'b0;
        repeat (3) cyc();
        hit[2] = 1'b1;
        repeat (5) cyc();
        hit[2] = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        hit[2] = 1'b1;
        repeat (5) cyc();
        hit[2] = 1'b0;
        check("rst_dead_pulses", pulses[2], 2);
        repeat (4) cyc();

`ifdef HIT_FILTER_GLITCH_EN
        dead_time = 8'd2;
        pulses[4] = 0;
        hit[4] = 1'b1; cyc();
        hit[4] = 1'b0;
        repeat (6) cyc();
        check("glitch_1cyc", pulses[4], 0);
        hit[4] = 1'b1;
        for (int j = 1; j <= LAT + 1; j++) begin
            cyc();
            if (j == 3) hit[4] = 1'b0;
            if (j == LAT) check("glitch_lat", filtered_hit[4], 1);
        end
        repeat (6) cyc();
        check("glitch_3cyc", pulses[4], 1);
`endif

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            hit = hit ^ (N_CH'($urandom) & N_CH'($urandom));
            if ($urandom_range(0, 99) < 3) ch_enable = N_CH'($urandom) | N_CH'($urandom);
            if ($urandom_range(0, 99) < 5) dead_time = 8'($urandom_range(0, 6));
            rst = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0;
        repeat (5) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
